// File: rtl/lfsr_pkg.sv
// lfsr_pkg
//   Shared definitions for the noise-channel LFSR.
//   - MODE_GAL / MODE_FIB : values of the lfsr_noise_gen 'mode' input.
//   - LFSR_MAX_W          : widest register lfsr_next() can evaluate.
//   - lfsr_next()         : one-step next-state function for either
//                           topology. Narrower registers are passed
//                           zero-extended, and their width is given in 'nbits'.
package lfsr_pkg;

  localparam logic MODE_GAL = 1'b0;
  localparam logic MODE_FIB = 1'b1;

  localparam int LFSR_MAX_W = 64;

  // Galois : fb = s[nbits-1]^invert; nxt = (s<<1) ^ (fb ? taps_gal : 0)
  // Fibonacci : fb = ^(s & taps_fib) ^ invert; nxt = {s[nbits-2:0], fb}
  // Bits above nbits-1 of the result are always zero, so callers can compare
  // the full-width result against their zero-extended state.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] state,
    input logic                  mode,
    input logic [LFSR_MAX_W-1:0] taps_gal,
    input logic [LFSR_MAX_W-1:0] taps_fib,
    input logic                  invert,
    input int unsigned           nbits
  );
    logic [LFSR_MAX_W-1:0] mask;
    logic [LFSR_MAX_W-1:0] shifted;
    logic [LFSR_MAX_W-1:0] msb_down;
    logic [LFSR_MAX_W-1:0] nxt;
    logic                  fb;
    mask     = {LFSR_MAX_W{1'b1}} >> (LFSR_MAX_W - nbits);
    shifted  = (state << 1) & mask;
    msb_down = state >> (nbits - 1);
    if (mode == MODE_FIB) begin
      fb  = (^(state & taps_fib & mask)) ^ invert;
      nxt = shifted | {{(LFSR_MAX_W-1){1'b0}}, fb};
    end else begin
      fb  = msb_down[0] ^ invert;
      nxt = shifted ^ (fb ? (taps_gal & mask) : '0);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr_prescaler.sv
// lfsr_prescaler
//   Step-rate divider: 'due' is high on every (rate+1)-th enabled cycle.
//   Ports:
//     clk    : system clock
//     reset  : synchronous, active-low
//     enable : advance the count; when low the count holds and nothing is due
//     clear  : force the count back to 0 (wins over enable)
//     rate   : terminal count; 0 means due every enabled cycle
//     due    : combinational, a step is due at the coming clock edge
module lfsr_prescaler #(
  parameter int unsigned RATE_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [RATE_W-1:0] rate,
  output logic              due
);

  logic [RATE_W-1:0] count_q;

  // ">=" rather than "==" so lowering rate below the running count
  // terminates on the next enabled cycle instead of wrapping the counter.
  assign due = enable && (count_q >= rate);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      if (due) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lfsr_noise_gen.sv
// lfsr_noise_gen
//   Noise source for one sound-generator channel: a Galois or Fibonacci LFSR
//   stepped by a programmable prescaler, with seed loading, stuck-state
//   recovery and a full-period strobe.
//   Ports:
//     clk         : system clock
//     reset       : synchronous, active-low; loads SEED
//     enable      : run the prescaler and allow steps
//     mode        : MODE_GAL (0) or MODE_FIB (1)
//     rate        : step every rate+1 enabled cycles
//     load        : single-cycle seed load strobe
//     load_data   : seed for load; also becomes the period reference
//     lfsr        : shift register state
//     noise       : lfsr MSB
//     step        : pulse, lfsr was shifted at the last edge
//     period_done : pulse with step when the new state equals the reference
//     lockup      : pulse, a stuck state was replaced by SEED
//   Per-cycle priority: reset, load, stuck recovery, step.
module lfsr_noise_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      NBITS    = 16,
  parameter logic [NBITS-1:0] TAPS_GAL = 16'h002D,
  parameter logic [NBITS-1:0] TAPS_FIB = 16'hB400,
  parameter bit               INVERT   = 1'b0,
  parameter logic [NBITS-1:0] SEED     = 16'h0001,
  parameter int unsigned      RATE_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mode,
  input  logic [RATE_W-1:0] rate,
  input  logic              load,
  input  logic [NBITS-1:0]  load_data,
  output logic [NBITS-1:0]  lfsr,
  output logic              noise,
  output logic              step,
  output logic              period_done,
  output logic              lockup
);

  logic [NBITS-1:0]      lfsr_q;
  logic [NBITS-1:0]      ref_seed_q;
  logic [LFSR_MAX_W-1:0] nxt_full;
  logic [NBITS-1:0]      nxt;
  logic                  stuck;
  logic                  due;
  logic                  presc_clear;
  logic                  step_q;
  logic                  period_done_q;
  logic                  lockup_q;

  // Next state and stuck detection in the current mode. The stuck test is a
  // fixed-point check (nxt == lfsr), so it covers all-zeros for XOR
  // feedback and the mode-specific all-ones-like point for XNOR feedback.
  // It runs every cycle, independent of enable.
  always_comb begin
    nxt_full = lfsr_next(LFSR_MAX_W'(lfsr_q), mode,
                         LFSR_MAX_W'(TAPS_GAL), LFSR_MAX_W'(TAPS_FIB),
                         INVERT, NBITS);
    nxt      = nxt_full[NBITS-1:0];
    stuck    = (nxt_full == LFSR_MAX_W'(lfsr_q));
  end

  // A load or a recovery restarts the step interval from zero.
  assign presc_clear = load | stuck;

  lfsr_prescaler #(
    .RATE_W (RATE_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (presc_clear),
    .rate   (rate),
    .due    (due)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q        <= SEED;
      ref_seed_q    <= SEED;
      step_q        <= 1'b0;
      period_done_q <= 1'b0;
      lockup_q      <= 1'b0;
    end else begin
      step_q        <= 1'b0;
      period_done_q <= 1'b0;
      lockup_q      <= 1'b0;
      if (load) begin
        // A step due in this same cycle is dropped.
        lfsr_q     <= load_data;
        ref_seed_q <= load_data;
      end else if (stuck) begin
        lfsr_q     <= SEED;
        ref_seed_q <= SEED;
        lockup_q   <= 1'b1;
      end else if (due) begin
        lfsr_q        <= nxt;
        step_q        <= 1'b1;
        period_done_q <= (nxt == ref_seed_q);
      end
    end
  end

  assign lfsr        = lfsr_q;
  assign noise       = lfsr_q[NBITS-1];
  assign step        = step_q;
  assign period_done = period_done_q;
  assign lockup      = lockup_q;

endmodule

// File: tb/tb_lfsr_noise_gen.sv
// tb_lfsr_noise_gen
//   Directed bench for lfsr_noise_gen with a 4-bit register:
//   TAPS_GAL=0011, TAPS_FIB=1001, SEED=0001, RATE_W=4.
//   Expected sequences are hand-computed tables.
module tb_lfsr_noise_gen;
  import lfsr_pkg::*;

  localparam int NB = 4;
  localparam int RW = 4;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          mode;
  logic [RW-1:0] rate;
  logic          load;
  logic [NB-1:0] load_data;
  logic [NB-1:0] lfsr;
  logic          noise;
  logic          step;
  logic          period_done;
  logic          lockup;

  int checks   = 0;
  int failures = 0;

  // Galois x^4+x+1 from 0001: state after step k is gal_tab[k-1].
  logic [NB-1:0] gal_tab[15] = '{4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0110,
                                 4'b1100, 4'b1011, 4'b0101, 4'b1010, 4'b0111,
                                 4'b1110, 4'b1111, 4'b1101, 4'b1001, 4'b0001};
  // Fibonacci taps 1001 from 0001.
  logic [NB-1:0] fib_tab[15] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101,
                                 4'b1010, 4'b0101, 4'b1011, 4'b0110, 4'b1100,
                                 4'b1001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  lfsr_noise_gen #(
    .NBITS    (NB),
    .TAPS_GAL (4'b0011),
    .TAPS_FIB (4'b1001),
    .INVERT   (1'b0),
    .SEED     (4'b0001),
    .RATE_W   (RW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .rate        (rate),
    .load        (load),
    .load_data   (load_data),
    .lfsr        (lfsr),
    .noise       (noise),
    .step        (step),
    .period_done (period_done),
    .lockup      (lockup)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge; outputs are sampled and inputs changed 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_pulses(input string tag, input logic s,
                              input logic pd, input logic lk);
    check({tag, ".step"}, 32'(step), 32'(s));
    check({tag, ".period_done"}, 32'(period_done), 32'(pd));
    check({tag, ".lockup"}, 32'(lockup), 32'(lk));
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    mode      = MODE_GAL;
    rate      = '0;
    load      = 1'b0;
    load_data = '0;

    // reset state
    tick();
    tick();
    check("rst.lfsr", 32'(lfsr), 32'h1);
    check("rst.noise", 32'(noise), 32'h0);
    check_pulses("rst", 1'b0, 1'b0, 1'b0);

    // Galois, rate 0: two full periods, period_done on steps 15 and 30
    reset  = 1'b1;
    enable = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      check($sformatf("gal.lfsr[%0d]", k), 32'(lfsr), 32'(gal_tab[(k-1)%15]));
      check($sformatf("gal.noise[%0d]", k), 32'(noise), 32'(gal_tab[(k-1)%15] >> 3));
      check($sformatf("gal.step[%0d]", k), 32'(step), 32'h1);
      check($sformatf("gal.pd[%0d]", k), 32'(period_done),
            32'((k == 15) || (k == 30)));
    end

    // Fibonacci from 0001, reference still SEED
    mode = MODE_FIB;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("fib.lfsr[%0d]", k), 32'(lfsr), 32'(fib_tab[k-1]));
      check($sformatf("fib.pd[%0d]", k), 32'(period_done), 32'(k == 15));
    end

    // prescaler rate 3: step on every 4th cycle (lfsr 0011, 0111, 1111)
    rate = 4'd3;
    for (int t = 0; t < 12; t++) begin
      tick();
      check($sformatf("presc.step[%0d]", t), 32'(step), 32'((t % 4) == 3));
    end
    check("presc.lfsr", 32'(lfsr), 32'b1111);

    // enable low for 5 cycles: nothing moves
    enable = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      check($sformatf("hold.step[%0d]", t), 32'(step), 32'h0);
      check($sformatf("hold.lfsr[%0d]", t), 32'(lfsr), 32'b1111);
    end
    enable = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      check($sformatf("resume.step[%0d]", t), 32'(step), 32'(t == 3));
    end
    check("resume.lfsr", 32'(lfsr), 32'b1110);

    // rate 10, run count to 7, then drop rate to 2: step on next cycle
    rate = 4'd10;
    for (int t = 0; t < 7; t++) begin
      tick();
      check($sformatf("r10.step[%0d]", t), 32'(step), 32'h0);
    end
    rate = 4'd2;
    tick();
    check("rdrop.step", 32'(step), 32'h1);
    check("rdrop.lfsr", 32'(lfsr), 32'b1101);

    // load collides with a due step (rate 2, due on the 3rd cycle)
    mode = MODE_GAL;
    tick();
    tick();
    check("precoll.step", 32'(step), 32'h0);
    load      = 1'b1;
    load_data = 4'b0101;
    tick();
    load = 1'b0;
    check("coll.lfsr", 32'(lfsr), 32'b0101);
    check_pulses("coll", 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 3; t++) begin
      tick();
      check($sformatf("postcoll.step[%0d]", t), 32'(step), 32'(t == 2));
    end
    check("postcoll.lfsr", 32'(lfsr), 32'b1010);

    // period now referenced to 0101 (gal_tab index 7), passing SEED quietly
    rate = 4'd0;
    for (int k = 2; k <= 15; k++) begin
      tick();
      check($sformatf("ref.lfsr[%0d]", k), 32'(lfsr), 32'(gal_tab[(7+k)%15]));
      check($sformatf("ref.pd[%0d]", k), 32'(period_done), 32'(k == 15));
    end

    // lock-up recovery while enabled
    load      = 1'b1;
    load_data = 4'b0000;
    tick();
    load = 1'b0;
    check("lock0.lfsr", 32'(lfsr), 32'h0);
    check_pulses("lock0", 1'b0, 1'b0, 1'b0);
    tick();
    check("lock1.lfsr", 32'(lfsr), 32'h1);
    check_pulses("lock1", 1'b0, 1'b0, 1'b1);
    tick();
    check("lock2.lfsr", 32'(lfsr), 32'b0010);
    check_pulses("lock2", 1'b1, 1'b0, 1'b0);

    // reset mid-run with count and lfsr non-zero
    rate = 4'd3;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mrst.lfsr", 32'(lfsr), 32'h1);
    check_pulses("mrst", 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 4; t++) begin
      tick();
      check($sformatf("mrst.step[%0d]", t), 32'(step), 32'(t == 3));
    end
    check("mrst.lfsr2", 32'(lfsr), 32'b0010);

    // lock-up recovery is independent of enable
    enable    = 1'b0;
    load      = 1'b1;
    load_data = 4'b0000;
    tick();
    load = 1'b0;
    check("dlock0.lfsr", 32'(lfsr), 32'h0);
    tick();
    check("dlock1.lfsr", 32'(lfsr), 32'h1);
    check("dlock1.lockup", 32'(lockup), 32'h1);
    tick();
    check("dlock2.lockup", 32'(lockup), 32'h0);
    check("dlock2.lfsr", 32'(lfsr), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
